// File: rtl/kbd_disp_pkg.sv
// Shared constants, FSM state type and a digit helper for the PS/2 key digit display.
package kbd_disp_pkg;

    // Digit code that the hex7seg decoders render as an unlit digit
    localparam logic [4:0] DIGIT_BLANK = 5'd16;

    // Scan code prefixes: break (key released) and extended-key marker
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Position in the make/break byte stream
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        BREAK   = 2'd2
    } kbd_state_t;

    // A 4-bit value shown as a hex digit (codes 0..15)
    function automatic logic [4:0] hex_digit(input logic [3:0] n);
        return {1'b0, n};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, 11-bit shift
// register, start/parity/stop check and a mid-frame inactivity timeout.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_prev;
    logic                   fall;
    logic [3:0]             bit_cnt;
    logic [3:0]             eff_cnt;
    logic [10:0]            shreg;
    logic [10:0]            frame_w;
    logic                   frame_ok;
    logic [TW-1:0]          to_cnt;
    logic                   timed_out;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Synchronise both PS/2 lines; reset to the idle-high bus level so no false edge follows reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // Edge detect, timeout qualification and frame assembly/check.
    // A timeout expiring on the same cycle as an edge restarts the frame so
    // that edge becomes bit 0 of the new frame.
    always_comb begin
        fall      = clk_prev & ~clk_s;
        timed_out = (bit_cnt != 4'd0) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
        eff_cnt   = timed_out ? 4'd0 : bit_cnt;
        frame_w   = {data_s, shreg[10:1]};
        frame_ok  = ~frame_w[0] & frame_w[10] & (^frame_w[9:1]);
    end

    // Bit counter, shift register, timeout counter and one-cycle result strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            shreg     <= '0;
            to_cnt    <= '0;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                shreg  <= frame_w;
                to_cnt <= '0;
                if (eff_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        rx_byte  <= frame_w[8:1];
                        rx_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= eff_cnt + 4'd1;
                end
            end else if (timed_out) begin
                bit_cnt <= 4'd0;
                to_cnt  <= '0;
            end else if (bit_cnt != 4'd0) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_digits.sv
// PS/2 keyboard to four hex7seg digit codes: held scan code (hi/lo nibble)
// and a two-digit BCD count of key presses with leading-zero blanking.
module ps2_key_digits
    import kbd_disp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] code_lo,
    output logic [4:0] code_hi,
    output logic [4:0] cnt_lo,
    output logic [4:0] cnt_hi,
    output logic       key_down,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;

    kbd_state_t state_q;
    kbd_state_t state_d;

    logic [7:0] cur_code;
    logic [3:0] ones_q;
    logic [3:0] tens_q;
    logic [3:0] ones_inc;
    logic [3:0] tens_inc;

    logic do_latch;
    logic do_count;
    logic do_release;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    // Decode FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: advances only on a received byte; extended prefixes never move it
    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_byte == SC_BREAK)    state_d = BREAK;
                    else if (rx_byte != SC_EXT) state_d = PRESSED;
                end
                PRESSED: begin
                    if (rx_byte == SC_BREAK) state_d = BREAK;
                end
                BREAK: begin
                    if (rx_byte != SC_EXT) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM actions: latch a new code (and count it), or release the held key
    always_comb begin
        do_latch   = 1'b0;
        do_count   = 1'b0;
        do_release = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_byte != SC_BREAK && rx_byte != SC_EXT) begin
                        do_latch = 1'b1;
                        do_count = 1'b1;
                    end
                end
                PRESSED: begin
                    if (rx_byte != SC_BREAK && rx_byte != SC_EXT && rx_byte != cur_code) begin
                        do_latch = 1'b1;
                        do_count = 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_byte != SC_EXT) do_release = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Two-digit BCD increment, 99 wraps to 00
    always_comb begin
        ones_inc = ones_q + 4'd1;
        tens_inc = tens_q;
        if (ones_q == 4'd9) begin
            ones_inc = 4'd0;
            tens_inc = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
        end
    end

    // Held code, key_down and scan-code digit registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_code <= 8'h00;
            key_down <= 1'b0;
            code_lo  <= DIGIT_BLANK;
            code_hi  <= DIGIT_BLANK;
        end else if (do_latch) begin
            cur_code <= rx_byte;
            key_down <= 1'b1;
            code_lo  <= hex_digit(rx_byte[3:0]);
            code_hi  <= hex_digit(rx_byte[7:4]);
        end else if (do_release) begin
            key_down <= 1'b0;
            code_lo  <= DIGIT_BLANK;
            code_hi  <= DIGIT_BLANK;
        end
    end

    // Press counter and its digit registers; tens digit blanks while zero
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            cnt_lo <= 5'd0;
            cnt_hi <= DIGIT_BLANK;
        end else if (do_count) begin
            ones_q <= ones_inc;
            tens_q <= tens_inc;
            cnt_lo <= hex_digit(ones_inc);
            cnt_hi <= (tens_inc == 4'd0) ? DIGIT_BLANK : hex_digit(tens_inc);
        end
    end

endmodule

// File: tb/tb_ps2_key_digits.sv
// Self-checking bench for ps2_key_digits: PS/2 frame driver, a key-tracking
// reference model, and a monitor that scores every received or rejected frame.
module tb_ps2_key_digits;

    localparam int TB_TIMEOUT = 300;
    localparam int HALF       = 4;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] code_lo;
    logic [4:0] code_hi;
    logic [4:0] cnt_lo;
    logic [4:0] cnt_hi;
    logic       key_down;
    logic       frame_err;

    int tests;
    int fails;

    // Reference model state: held key (-1 = none), press count, break pending
    int m_held;
    int m_count;
    bit m_brk;

    // {err, key_down, code_hi, code_lo, cnt_hi, cnt_lo}
    logic [21:0] exp_q[$];

    ps2_key_digits #(
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .SYNC_STAGES   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .code_lo  (code_lo),
        .code_hi  (code_hi),
        .cnt_lo   (cnt_lo),
        .cnt_hi   (cnt_hi),
        .key_down (key_down),
        .frame_err(frame_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] model_outputs(input bit err);
        logic [4:0] lo, hi, clo, chi;
        lo  = (m_held < 0) ? 5'd16 : 5'(m_held % 16);
        hi  = (m_held < 0) ? 5'd16 : 5'(m_held / 16);
        clo = 5'(m_count % 10);
        chi = (m_count < 10) ? 5'd16 : 5'(m_count / 10);
        return {err, (m_held >= 0), hi, lo, chi, clo};
    endfunction

    task automatic model_reset();
        m_held  = -1;
        m_count = 0;
        m_brk   = 0;
    endtask

    // Apply one valid byte to the model and queue the expected display
    task automatic model_byte(input logic [7:0] b);
        int v;
        v = int'(b);
        if (m_brk) begin
            if (v != 'hE0) begin
                m_held = -1;
                m_brk  = 0;
            end
        end else if (v == 'hF0) begin
            m_brk = 1;
        end else if (v != 'hE0 && v != m_held) begin
            m_held  = v;
            m_count = (m_count + 1) % 100;
        end
        exp_q.push_back(model_outputs(1'b0));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the first n bits of a frame (start, data LSB first, parity, stop)
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int n);
        logic [10:0] bits;
        logic        par;
        par  = ~(^b) ^ bad_par;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        wait_cycles(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_bits(b, 1'b0, 11);
        wait_cycles(12);
    endtask

    task automatic send_bad(input logic [7:0] b);
        exp_q.push_back(model_outputs(1'b1));
        send_bits(b, 1'b1, 11);
        wait_cycles(12);
    endtask

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {frame_err, key_down, code_hi, code_lo, cnt_hi, cnt_lo},
              {1'b0, 1'b0, 5'd16, 5'd16, 5'd16, 5'd0});
    endtask

    // Monitor: each received byte or frame error is scored one cycle later
    initial begin
        logic        got_err;
        logic [21:0] act;
        forever begin
            @(negedge clk);
            if (dut.rx_valid || frame_err) begin
                got_err = frame_err;
                @(negedge clk);
                act = {got_err, key_down, code_hi, code_lo, cnt_hi, cnt_lo};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got %h expected none", act);
                end else begin
                    check("frame_result", act, exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] k;
        int         r;
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(10);

        // Reset state
        check_reset_outputs("reset_state");

        // Press, typematic repeats, break
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);

        // Parity error: pulse only, display unchanged
        send_bad(8'h1C);

        // Partial frame then timeout, then a clean frame
        send_bits(8'h55, 1'b0, 5);
        wait_cycles(TB_TIMEOUT + 10);
        send_byte(8'h2A);
        send_byte(8'hF0);
        send_byte(8'h2A);

        // Extended key press and release
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);

        // Reset mid-frame, then a full frame
        send_bits(8'h33, 1'b0, 4);
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        model_reset();
        wait_cycles(10);
        check_reset_outputs("reset_midframe");
        send_byte(8'h16);

        // 100 press/break pairs from a fresh count: crosses 9->10 and 99->00
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        model_reset();
        wait_cycles(10);
        check_reset_outputs("reset_before_count");
        for (int i = 0; i < 100; i++) begin
            do k = 8'($urandom_range(1, 8'hDF)); while (k == 8'hE0 || k == 8'hF0);
            send_byte(k);
            send_byte(8'hF0);
            send_byte(k);
            if (i == 9)  check("count_ten",  {cnt_hi, cnt_lo}, {5'd1, 5'd0});
            if (i == 99) check("count_wrap", {cnt_hi, cnt_lo}, {5'd16, 5'd0});
        end

        // Random byte stream including prefixes, repeats and bad frames
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      send_byte(8'hF0);
            else if (r < 30) send_byte(8'hE0);
            else if (r < 35) send_bad(8'($urandom_range(0, 255)));
            else if (r < 50) send_byte(8'(m_held < 0 ? 8'h1C : m_held));
            else             send_byte(8'($urandom_range(0, 255)));
        end

        wait_cycles(50);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
